// File: rtl/run_ctrl_if.sv
// Launch/complete handshake and status counters between run_ctrl and the datapath.
// run_ctrl drives through the master modport; the datapath side uses slave.
interface run_ctrl_if #(
  parameter int NSINK = 3
);
  localparam int CHW = (NSINK > 1) ? $clog2(NSINK) : 1;

  logic           enable;
  logic           sink_eop;
  logic           source_start;
  logic [CHW-1:0] source_chan;
  logic           busy;
  logic [15:0]    run_cnt;
  logic [7:0]     overrun_cnt;
  logic [7:0]     timeout_cnt;

  modport master (
    input  enable, sink_eop,
    output source_start, source_chan, busy, run_cnt, overrun_cnt, timeout_cnt
  );

  modport slave (
    output enable, sink_eop,
    input  source_start, source_chan, busy, run_cnt, overrun_cnt, timeout_cnt
  );
endinterface

// File: rtl/run_ctrl.sv
// Periodic run launcher: round-robin channel sequencing, overrun/timeout accounting.
// Define RUN_CTRL_TIMEOUT_EN to compile in the in-flight watchdog.
module run_ctrl #(
  parameter int NSINK   = 3,
  parameter int TICKS   = 4096,
  parameter int TIMEOUT = 8192
) (
  input  logic          clk,
  input  logic          reset,
  run_ctrl_if.master    bus
);
  localparam int CHW = (NSINK > 1) ? $clog2(NSINK) : 1;
  localparam int CW  = $clog2(TICKS);

  if (TICKS < 4 || TIMEOUT < 1) begin : g_bad_cfg
    $error("run_ctrl: TICKS must be >= 4 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           tick;
  logic           launch, run_inc, ovr_inc, wd_expired;
  logic           start_q;
  logic [CHW-1:0] chan_q;
  logic [15:0]    run_q;
  logic [7:0]     ovr_q;

  assign tick = bus.enable && (cnt == CW'(TICKS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !bus.enable || cnt == CW'(TICKS - 1)) cnt <= '0;
    else                                               cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    run_inc   = 1'b0;
    ovr_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          launch    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A run ending (normally or by watchdog) on a tick hands straight over to the next run.
        if (bus.sink_eop || wd_expired) begin
          run_inc = bus.sink_eop;
          launch  = tick;
          if (!tick) state_nxt = IDLE;
        end else if (tick) begin
          ovr_inc = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      chan_q  <= '0;
      run_q   <= '0;
      ovr_q   <= '0;
    end else begin
      start_q <= launch;
      if (launch) chan_q <= (chan_q == CHW'(NSINK - 1)) ? '0 : chan_q + CHW'(1);
      if (run_inc) run_q <= run_q + 16'd1;
      if (ovr_inc && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end
  end

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd;
  logic [7:0]    to_q;

  always_ff @(posedge clk) begin
    if (reset || launch)     wd <= '0;
    else if (state == BUSY)  wd <= wd + WW'(1);
  end

  // wd counts the start cycle as zero, so the TIMEOUT-th busy cycle is the last one.
  assign wd_expired = (state == BUSY) && (wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) to_q <= '0;
    else if (wd_expired && !bus.sink_eop && to_q != 8'hFF) to_q <= to_q + 8'd1;
  end

  assign bus.timeout_cnt = to_q;
`else
  assign wd_expired      = 1'b0;
  assign bus.timeout_cnt = '0;
`endif

  assign bus.source_start = start_q;
  assign bus.source_chan  = chan_q;
  assign bus.busy         = (state == BUSY);
  assign bus.run_cnt      = run_q;
  assign bus.overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: expected launches (cycle, channel) are queued
// as stimulus is scheduled and matched against every observed source_start.
module tb_run_ctrl;
  localparam int NSINK   = 3;
  localparam int TICKS   = 16;
  localparam int TIMEOUT = 40;

  typedef struct {
    int cyc;
    int chan;
  } start_t;

  logic   clk = 1'b0;
  logic   reset;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     exp_chan = 0;
  logic   prev_start = 1'b0;
  start_t exp_q[$];

  run_ctrl_if #(.NSINK(NSINK)) bus ();

  run_ctrl #(.NSINK(NSINK), .TICKS(TICKS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic sample_at(input int c);
    run_to(c);
    @(negedge clk);
  endtask

  task automatic pulse_eop(input int c);
    run_to(c);
    bus.sink_eop = 1'b1;
    step();
    bus.sink_eop = 1'b0;
  endtask

  task automatic expect_start(input int c);
    start_t s;
    exp_chan = (exp_chan + 1) % NSINK;
    s.cyc  = c;
    s.chan = exp_chan;
    exp_q.push_back(s);
  endtask

  // Start monitor: every launch must be expected, on time, on the right channel, never back-to-back.
  always @(negedge clk) begin
    if (bus.source_start === 1'b1) begin
      check("start_back2back", int'(prev_start), 0);
      check("start_busy", int'(bus.busy), 1);
      check("start_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        start_t s;
        s = exp_q.pop_front();
        check("start_cyc", cyc, s.cyc);
        check("start_chan", int'(bus.source_chan), s.chan);
      end
    end
    prev_start = bus.source_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int e, f, s;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.sink_eop = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_start", int'(bus.source_start), 0);
    check("rst_chan", int'(bus.source_chan), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_run", int'(bus.run_cnt), 0);
    check("rst_ovr", int'(bus.overrun_cnt), 0);
    check("rst_to", int'(bus.timeout_cnt), 0);

    // Normal runs: eop 5 cycles after each start.
    step();
    reset      = 1'b0;
    bus.enable = 1'b1;
    e = cyc;
    for (int k = 0; k < 4; k++) begin
      s = e + TICKS + TICKS * k;
      expect_start(s);
      if (k == 0) begin
        sample_at(s + 5);
        check("busy_at_eop", int'(bus.busy), 1);
      end
      pulse_eop(s + 5);
      if (k == 0) begin
        sample_at(s + 6);
        check("busy_after_eop", int'(bus.busy), 0);
      end
    end
    sample_at(e + 70);
    check("run_cnt_4", int'(bus.run_cnt), 4);
    check("ovr_0", int'(bus.overrun_cnt), 0);

    // Slow run: eop 20 cycles after start skips one tick.
    expect_start(e + 80);
    pulse_eop(e + 100);
    sample_at(e + 101);
    check("run_cnt_5", int'(bus.run_cnt), 5);
    check("ovr_1", int'(bus.overrun_cnt), 1);
    check("busy_idle_slow", int'(bus.busy), 0);

    // eop coincident with a tick: immediate relaunch.
    expect_start(e + 112);
    expect_start(e + 128);
    pulse_eop(e + 127);
    sample_at(e + 128);
    check("b2b_busy", int'(bus.busy), 1);
    check("b2b_run", int'(bus.run_cnt), 6);
    check("b2b_ovr", int'(bus.overrun_cnt), 1);

    // enable dropped mid-run: run completes, no further launches.
    run_to(e + 130);
    bus.enable = 1'b0;
    pulse_eop(e + 138);
    sample_at(e + 139);
    check("dis_run", int'(bus.run_cnt), 7);
    check("dis_busy", int'(bus.busy), 0);
    sample_at(e + 200);
    check("dis_still_idle", int'(bus.busy), 0);

    // Reset mid-run discards the run; channel order restarts at 1.
    bus.enable = 1'b1;
    f = cyc;
    expect_start(f + 16);
    run_to(f + 19);
    reset = 1'b1;
    step();
    reset    = 1'b0;
    exp_chan = 0;
    sample_at(f + 20);
    check("mrst_start", int'(bus.source_start), 0);
    check("mrst_chan", int'(bus.source_chan), 0);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_run", int'(bus.run_cnt), 0);
    check("mrst_ovr", int'(bus.overrun_cnt), 0);
    check("mrst_to", int'(bus.timeout_cnt), 0);
    pulse_eop(f + 24);
    sample_at(f + 25);
    check("idle_eop_run", int'(bus.run_cnt), 0);
    check("idle_eop_busy", int'(bus.busy), 0);
    expect_start(f + 36);
    pulse_eop(f + 41);
    sample_at(f + 42);
    check("post_rst_run", int'(bus.run_cnt), 1);

    // Run that never completes.
    s = f + 52;
    expect_start(s);
`ifdef RUN_CTRL_TIMEOUT_EN
    sample_at(s + TIMEOUT - 1);
    check("wd_busy_last", int'(bus.busy), 1);
    check("wd_ovr", int'(bus.overrun_cnt), 2);
    sample_at(s + TIMEOUT);
    check("wd_busy_drop", int'(bus.busy), 0);
    check("wd_to", int'(bus.timeout_cnt), 1);
    check("wd_run", int'(bus.run_cnt), 1);
    expect_start(s + 48);
    pulse_eop(s + 53);
    sample_at(s + 54);
    check("wd_next_run", int'(bus.run_cnt), 2);
    check("wd_to_hold", int'(bus.timeout_cnt), 1);
`else
    sample_at(s + 15 + TICKS * 254);
    check("ovr_254", int'(bus.overrun_cnt), 254);
    sample_at(s + 16 + TICKS * 254);
    check("ovr_255", int'(bus.overrun_cnt), 255);
    sample_at(s + 16 + TICKS * 262);
    check("ovr_sat", int'(bus.overrun_cnt), 255);
    check("hang_busy", int'(bus.busy), 1);
    check("hang_to", int'(bus.timeout_cnt), 0);
    check("hang_run", int'(bus.run_cnt), 1);
`endif

    step();
    check("starts_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter NSINK, default 3, number of antenna channels sequenced round-robin.
REQ-002 The block SHALL have parameter TICKS, default 4096, run period in clk cycles (>=4).
REQ-003 The block SHALL have parameter TIMEOUT, default 8192, maximum clk cycles a run may stay in flight.
REQ-004 The block SHALL have port clk, input, 1, single clock, all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1, permits new runs while high.
REQ-007 The block SHALL have port sink_eop, input, 1, single-cycle pulse marking the last result entry of the current run.
REQ-008 The block SHALL have port source_start, output, 1, single-cycle pulse launching a run in the datapath.
REQ-009 The block SHALL have port source_chan, output, $clog2(NSINK) (min 1), channel index for the launched run, stable while busy.
REQ-010 The block SHALL have port busy, output, 1, high while a run is in flight.
REQ-011 The block SHALL have port run_cnt, output, 16, completed runs, wraps 65535->0.
REQ-012 The block SHALL have port overrun_cnt, output, 8, skipped launches, saturates at 255.
REQ-013 The block SHALL have port timeout_cnt, output, 8, aborted runs, saturates at 255.

Function
REQ-014 Period counter SHALL count 0..TICKS-1 and wrap while enable=1; SHALL hold at 0 while enable=0; tick = (cnt==TICKS-1 && enable).
REQ-015 FSM SHALL have states IDLE and BUSY only.
REQ-016 IDLE + tick: source_start=1 in the next cycle, source_chan advances (wrap NSINK-1->0) in that same cycle, state->BUSY.
REQ-017 BUSY + sink_eop: run_cnt+1, state->IDLE.
REQ-018 BUSY + tick + no sink_eop: no launch, overrun_cnt+1 (saturating), stay BUSY.
REQ-019 BUSY + tick + sink_eop same cycle: run_cnt+1 and a new launch issued per REQ-016; state stays BUSY; overrun_cnt unchanged.
REQ-020 sink_eop in IDLE SHALL be ignored (no counter change).
REQ-021 enable falling while BUSY SHALL NOT abort the run; completion handled normally; no further launches.
REQ-022 source_start SHALL never be high on two consecutive cycles; busy SHALL be high from the source_start cycle until the cycle after the accepted sink_eop.
REQ-023 The first launch after enable rises SHALL occur TICKS cycles after the first enable=1 cycle.

Reset
REQ-024 reset=1 SHALL force on the next edge: state IDLE, cnt 0, source_start 0, source_chan 0, busy 0, run_cnt 0, overrun_cnt 0, timeout_cnt 0.
REQ-025 reset SHALL override all other inputs, including mid-run; the in-flight run is discarded without counting.
REQ-026 The first launch after reset release uses source_chan=1 (advance from 0); channel order 1,2,0,1,...

Configuration
REQ-027 Macro RUN_CTRL_TIMEOUT_EN SHALL compile in the watchdog: a cycle counter cleared on launch; counts in BUSY; reaching TIMEOUT forces IDLE, timeout_cnt+1 (saturating), run_cnt unchanged; a tick in that cycle launches per REQ-016.
REQ-028 Without RUN_CTRL_TIMEOUT_EN, BUSY SHALL wait indefinitely for sink_eop; timeout_cnt SHALL be constant 0; TIMEOUT is unused.

Verification (TICKS=16, NSINK=3, TIMEOUT=40)
REQ-029 Reset release, enable=1, sink_eop 5 cycles after each start -> starts every 16 cycles, chan 1,2,0,1; run_cnt=4 after 4 runs; overrun_cnt=0.
REQ-030 sink_eop 20 cycles after start -> next tick skipped, overrun_cnt=1, next launch 32 cycles after previous, chan advances by one only.
REQ-031 sink_eop coincident with tick while BUSY -> start next cycle, busy stays 1, run_cnt+1, overrun_cnt unchanged.
REQ-032 With RUN_CTRL_TIMEOUT_EN, never assert sink_eop -> busy drops 40 cycles after start, timeout_cnt=1; without macro busy stays 1 and overrun_cnt climbs to 255 and holds.
REQ-033 reset pulsed 3 cycles after a start -> all outputs zero next cycle; later sink_eop ignored; first new start has chan=1.
REQ-034 enable dropped while BUSY, sink_eop 8 cycles later -> run_cnt+1, busy 0, no further source_start while enable=0.
